// File: rtl/vga_mode_ctrl_if.sv
// Bundles the host register/command port, the generator counter feedback and the
// timing/status outputs of the VGA mode controller.
interface vga_mode_ctrl_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [9:0] wr_data;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_commit;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic       timing_reset;
  logic       timing_enabled;
  logic [9:0] h_sync_start;
  logic [9:0] h_sync_end;
  logic [9:0] h_active_start;
  logic [9:0] h_active_end;
  logic [9:0] v_sync_start;
  logic [9:0] v_sync_end;
  logic [9:0] v_active_start;
  logic [9:0] v_active_end;
  logic       h_pol;
  logic       v_pol;
  logic       busy;
  logic       cfg_err;
  logic       frame_pulse;

  modport slave (
    input  wr_en, wr_addr, wr_data, cmd_start, cmd_stop, cmd_commit, h_counter, v_counter,
    output timing_reset, timing_enabled, h_sync_start, h_sync_end, h_active_start,
           h_active_end, v_sync_start, v_sync_end, v_active_start, v_active_end,
           h_pol, v_pol, busy, cfg_err, frame_pulse
  );

  modport master (
    output wr_en, wr_addr, wr_data, cmd_start, cmd_stop, cmd_commit, h_counter, v_counter,
    input  timing_reset, timing_enabled, h_sync_start, h_sync_end, h_active_start,
           h_active_end, v_sync_start, v_sync_end, v_active_start, v_active_end,
           h_pol, v_pol, busy, cfg_err, frame_pulse
  );
endinterface

// File: rtl/vga_mode_ctrl.sv
// VGA mode controller: shadow/staged/active timing banks with validated commits,
// applied at once when stopped or on the last pixel of a frame when running.
module vga_mode_ctrl #(
  parameter logic [9:0] DEF_H_SYNC_START   = 10'd0,
  parameter logic [9:0] DEF_H_SYNC_END     = 10'd95,
  parameter logic [9:0] DEF_H_ACTIVE_START = 10'd144,
  parameter logic [9:0] DEF_H_ACTIVE_END   = 10'd783,
  parameter logic [9:0] DEF_V_SYNC_START   = 10'd0,
  parameter logic [9:0] DEF_V_SYNC_END     = 10'd1,
  parameter logic [9:0] DEF_V_ACTIVE_START = 10'd35,
  parameter logic [9:0] DEF_V_ACTIVE_END   = 10'd514,
  parameter logic [1:0] DEF_POL            = 2'b00
) (
  input  logic           clk,
  input  logic           reset,
  vga_mode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

  // Field index order: hss, hse, has, hae, vss, vse, vas, vae
  localparam logic [7:0][9:0] DEF_BANK = {DEF_V_ACTIVE_END, DEF_V_ACTIVE_START,
                                          DEF_V_SYNC_END, DEF_V_SYNC_START,
                                          DEF_H_ACTIVE_END, DEF_H_ACTIVE_START,
                                          DEF_H_SYNC_END, DEF_H_SYNC_START};

  state_t           r_state, w_state_nxt;
  logic [7:0][9:0]  r_sh, r_stg, r_act;
  logic [1:0]       r_sh_pol, r_stg_pol, r_act_pol;
  logic             r_tmg_rst, r_tmg_en, r_err, r_fp;

  logic w_h_ok, w_v_ok, w_valid, w_boundary;
  logic w_stop, w_start, w_commit;
  logic w_ld_act_sh, w_ld_act_stg, w_ld_stg, w_set_err, w_clr_err;

  assign w_h_ok = (r_sh[0] <= r_sh[1]) && (r_sh[2] <= r_sh[3]) &&
                  (r_sh[1] <= r_sh[3]) && (r_sh[3] != '0);
  assign w_v_ok = (r_sh[4] <= r_sh[5]) && (r_sh[6] <= r_sh[7]) &&
                  (r_sh[5] <= r_sh[7]) && (r_sh[7] != '0);
  assign w_valid    = w_h_ok && w_v_ok;
  assign w_boundary = (bus.h_counter == r_act[3]) && (bus.v_counter == r_act[7]);

  // A higher-priority command drops lower ones even when it is itself ignored
  assign w_stop   = bus.cmd_stop;
  assign w_start  = bus.cmd_start && !bus.cmd_stop;
  assign w_commit = bus.cmd_commit && !bus.cmd_start && !bus.cmd_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ld_act_sh  = 1'b0;
    w_ld_act_stg = 1'b0;
    w_ld_stg     = 1'b0;
    w_set_err    = 1'b0;
    w_clr_err    = 1'b0;
    if (w_commit) begin
      w_set_err = !w_valid;
      w_clr_err = w_valid;
      w_ld_stg  = w_valid;
    end
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = RUN;
        else         w_ld_act_sh = w_commit && w_valid;
      end
      RUN: begin
        if (w_stop)                   w_state_nxt = IDLE;
        else if (w_commit && w_valid) w_state_nxt = PENDING;
      end
      PENDING: begin
        if (w_stop) begin
          w_ld_act_stg = 1'b1;
          w_state_nxt  = IDLE;
        end else begin
          // Boundary applies the old staged bank; a same-cycle valid commit re-arms PENDING
          w_ld_act_stg = w_boundary;
          if (w_boundary && !(w_commit && w_valid)) w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh      <= DEF_BANK;
      r_stg     <= DEF_BANK;
      r_act     <= DEF_BANK;
      r_sh_pol  <= DEF_POL;
      r_stg_pol <= DEF_POL;
      r_act_pol <= DEF_POL;
      r_tmg_rst <= 1'b1;
      r_tmg_en  <= 1'b0;
      r_err     <= 1'b0;
      r_fp      <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        if (bus.wr_addr < 4'd8)       r_sh[bus.wr_addr[2:0]] <= bus.wr_data;
        else if (bus.wr_addr == 4'd8) r_sh_pol <= bus.wr_data[1:0];
      end
      if (w_ld_stg) begin
        r_stg     <= r_sh;
        r_stg_pol <= r_sh_pol;
      end
      if (w_ld_act_sh) begin
        r_act     <= r_sh;
        r_act_pol <= r_sh_pol;
      end else if (w_ld_act_stg) begin
        r_act     <= r_stg;
        r_act_pol <= r_stg_pol;
      end
      if (w_set_err)      r_err <= 1'b1;
      else if (w_clr_err) r_err <= 1'b0;
      r_tmg_rst <= (r_state == IDLE);
      r_tmg_en  <= (r_state != IDLE);
      r_fp      <= w_boundary && (r_state != IDLE);
    end
  end

  assign bus.timing_reset   = r_tmg_rst;
  assign bus.timing_enabled = r_tmg_en;
  assign bus.h_sync_start   = r_act[0];
  assign bus.h_sync_end     = r_act[1];
  assign bus.h_active_start = r_act[2];
  assign bus.h_active_end   = r_act[3];
  assign bus.v_sync_start   = r_act[4];
  assign bus.v_sync_end     = r_act[5];
  assign bus.v_active_start = r_act[6];
  assign bus.v_active_end   = r_act[7];
  assign bus.h_pol          = r_act_pol[0];
  assign bus.v_pol          = r_act_pol[1];
  assign bus.busy           = (r_state == PENDING);
  assign bus.cfg_err        = r_err;
  assign bus.frame_pulse    = r_fp;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_vga_mode_ctrl;
  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  vga_mode_ctrl_if bus ();

  vga_mode_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_TR = 0, S_EN = 1, S_HSS = 2, S_HSE = 3, S_HAE = 4, S_VAE = 5,
                 S_HPOL = 6, S_VPOL = 7, S_BUSY = 8, S_ERR = 9, S_FP = 10;

  typedef struct {
    int unsigned cyc;
    int          sig;
    logic [9:0]  val;
    string       name;
  } exp_t;

  exp_t q[$];

  function automatic logic [9:0] getsig(input int s);
    case (s)
      S_TR:    return {9'd0, bus.timing_reset};
      S_EN:    return {9'd0, bus.timing_enabled};
      S_HSS:   return bus.h_sync_start;
      S_HSE:   return bus.h_sync_end;
      S_HAE:   return bus.h_active_end;
      S_VAE:   return bus.v_active_end;
      S_HPOL:  return {9'd0, bus.h_pol};
      S_VPOL:  return {9'd0, bus.v_pol};
      S_BUSY:  return {9'd0, bus.busy};
      S_ERR:   return {9'd0, bus.cfg_err};
      S_FP:    return {9'd0, bus.frame_pulse};
      default: return 10'h3FF;
    endcase
  endfunction

  // Monitor: compares every expectation stamped for the current cycle
  always @(negedge clk) begin
    exp_t e;
    logic [9:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      act = getsig(e.sig);
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: check missed (stamp %0d now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        bad++;
        $display("FAIL %s: cycle %0d got %0d expected %0d", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic ex(input string nm, input int s, input logic [9:0] v);
    q.push_back('{cyc, s, v, nm});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic stp, input logic sta, input logic com,
                       input logic we, input logic [3:0] a, input logic [9:0] d);
    bus.cmd_stop   = stp;
    bus.cmd_start  = sta;
    bus.cmd_commit = com;
    bus.wr_en      = we;
    bus.wr_addr    = a;
    bus.wr_data    = d;
    tick();
    bus.cmd_stop   = 1'b0;
    bus.cmd_start  = 1'b0;
    bus.cmd_commit = 1'b0;
    bus.wr_en      = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [9:0] d);
    drive(1'b0, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic commit();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 10'd0);
  endtask

  task automatic start();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 10'd0);
  endtask

  task automatic set_ctr(input logic [9:0] h, input logic [9:0] v);
    bus.h_counter = h;
    bus.v_counter = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cmd_stop = 1'b0; bus.cmd_start = 1'b0; bus.cmd_commit = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    set_ctr(10'd0, 10'd0);
    tick(); tick();
    reset = 1'b0;
    ex("rst_tr", S_TR, 10'd1);   ex("rst_en", S_EN, 10'd0);
    ex("rst_hae", S_HAE, 10'd783); ex("rst_vae", S_VAE, 10'd514);
    ex("rst_busy", S_BUSY, 10'd0); ex("rst_err", S_ERR, 10'd0);
    ex("rst_fp", S_FP, 10'd0);

    // Commit in IDLE applies directly
    wr(4'd3, 10'd799);
    ex("idle_pre_hae", S_HAE, 10'd783);
    commit();
    ex("idle_commit_hae", S_HAE, 10'd799); ex("idle_commit_busy", S_BUSY, 10'd0);
    tick();
    ex("idle_still_tr", S_TR, 10'd1);
    wr(4'd8, 10'd3);
    wr(4'd3, 10'd783);
    commit();
    ex("idle_hpol", S_HPOL, 10'd1); ex("idle_vpol", S_VPOL, 10'd1);
    ex("idle_restore_hae", S_HAE, 10'd783);

    // Start, then a deferred commit applied on the frame boundary
    start();
    ex("start_tr_lag", S_TR, 10'd1);
    tick();
    ex("run_tr", S_TR, 10'd0); ex("run_en", S_EN, 10'd1);
    set_ctr(10'd100, 10'd200);
    wr(4'd3, 10'd639);
    commit();
    ex("pend_busy", S_BUSY, 10'd1); ex("pend_hae_hold", S_HAE, 10'd783);
    tick(); tick();
    ex("pend_hae_hold2", S_HAE, 10'd783); ex("pend_fp_low", S_FP, 10'd0);
    set_ctr(10'd783, 10'd514);
    ex("bnd_cycle_hae", S_HAE, 10'd783); ex("bnd_cycle_busy", S_BUSY, 10'd1);
    tick();
    set_ctr(10'd0, 10'd0);
    ex("bnd_hae", S_HAE, 10'd639); ex("bnd_busy", S_BUSY, 10'd0);
    ex("bnd_fp", S_FP, 10'd1);
    tick();
    ex("bnd_fp_one", S_FP, 10'd0);

    // Invalid commit rejected, then corrected
    wr(4'd0, 10'd100);
    wr(4'd1, 10'd90);
    commit();
    ex("bad_err", S_ERR, 10'd1); ex("bad_busy", S_BUSY, 10'd0);
    ex("bad_hss", S_HSS, 10'd0); ex("bad_hse", S_HSE, 10'd95);
    wr(4'd1, 10'd190);
    commit();
    ex("fix_err", S_ERR, 10'd0); ex("fix_busy", S_BUSY, 10'd1);
    // A rejected commit while pending leaves the staged change intact
    wr(4'd7, 10'd0);
    commit();
    ex("pend_bad_err", S_ERR, 10'd1); ex("pend_bad_busy", S_BUSY, 10'd1);
    wr(4'd7, 10'd514);
    set_ctr(10'd639, 10'd514);
    tick();
    set_ctr(10'd0, 10'd0);
    ex("fix_hss", S_HSS, 10'd100); ex("fix_hse", S_HSE, 10'd190);
    ex("fix_vae", S_VAE, 10'd514); ex("fix_fp", S_FP, 10'd1);

    // Stop and commit together while pending: stop wins
    wr(4'd3, 10'd700);
    commit();
    ex("sc_busy", S_BUSY, 10'd1);
    wr(4'd3, 10'd650);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 10'd0);
    ex("sc_hae", S_HAE, 10'd700); ex("sc_busy_off", S_BUSY, 10'd0);
    ex("sc_err", S_ERR, 10'd0);
    tick();
    ex("sc_tr", S_TR, 10'd1); ex("sc_en", S_EN, 10'd0);
    ex("sc_hae_hold", S_HAE, 10'd700);

    // Recommit while pending; same-cycle write excluded from that commit
    start();
    wr(4'd3, 10'd600);
    commit();
    wr(4'd3, 10'd620);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 10'd630);
    ex("re_busy", S_BUSY, 10'd1); ex("re_hae_hold", S_HAE, 10'd700);
    set_ctr(10'd700, 10'd514);
    tick();
    set_ctr(10'd0, 10'd0);
    ex("re_hae", S_HAE, 10'd620); ex("re_busy_off", S_BUSY, 10'd0);
    commit();
    ex("wr_busy", S_BUSY, 10'd1);
    set_ctr(10'd620, 10'd514);
    tick();
    set_ctr(10'd0, 10'd0);
    ex("wr_landed_hae", S_HAE, 10'd630);

    // Asynchronous reset while pending
    wr(4'd3, 10'd610);
    commit();
    ex("ar_busy_pre", S_BUSY, 10'd1); ex("ar_hae_pre", S_HAE, 10'd630);
    tick();
    #2;
    reset = 1'b1;
    ex("ar_tr", S_TR, 10'd1);     ex("ar_en", S_EN, 10'd0);
    ex("ar_busy", S_BUSY, 10'd0); ex("ar_hae", S_HAE, 10'd783);
    ex("ar_hss", S_HSS, 10'd0);   ex("ar_hse", S_HSE, 10'd95);
    ex("ar_hpol", S_HPOL, 10'd0); ex("ar_err", S_ERR, 10'd1 - 10'd1);
    ex("ar_fp", S_FP, 10'd0);
    tick();
    set_ctr(10'd610, 10'd514);
    tick();
    reset = 1'b0;
    tick();
    ex("ar_post_hae", S_HAE, 10'd783); ex("ar_post_busy", S_BUSY, 10'd0);
    ex("ar_post_tr", S_TR, 10'd1);     ex("ar_post_fp", S_FP, 10'd0);
    tick();
    ex("ar_post_hae2", S_HAE, 10'd783);

    tick(); tick();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
